// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory controller
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } dmem_state_t;

    localparam int RD_LAT_MAX = 4;
    localparam int LAT_W      = $clog2(RD_LAT_MAX);
    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x DATA_W synchronous storage, byte-lane writes, registered read
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write and registered read; contents are never reset, rdata holds between reads
    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory controller: request/response FSM, read latency, range check (optional perf counters: DMEM_PERF_CNT_EN)
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_rd,
    output logic [PERF_CNT_W-1:0] perf_wr,
    output logic [PERF_CNT_W-1:0] perf_err
`endif
);

    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

    dmem_state_t       state;
    logic [LAT_W-1:0]  lat_cnt;
    logic              in_range;
    logic              accept;
    logic              arr_we;
    logic              arr_re;
    logic [DATA_W-1:0] arr_rdata;

    assign req_ready = enable & (state == ST_IDLE) & ~reset;
    assign accept    = req_valid & req_ready;
    assign in_range  = ({1'b0, req_addr} < DEPTH_L);
    assign arr_we    = accept & req_we & in_range;
    assign arr_re    = accept & ~req_we & in_range;

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clock (clock),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (req_addr),
        .wdata (req_wdata),
        .be    (req_be),
        .rdata (arr_rdata)
    );

    // Transaction FSM with registered response; everything holds while enable is low
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            lat_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (enable) begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!req_we && in_range) begin
                            state   <= ST_RD_WAIT;
                            lat_cnt <= '0;
                        end else begin
                            // Writes and any out-of-range access answer on the next cycle
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_err   <= ~in_range;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= arr_rdata;
                        rsp_err   <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_PERF_CNT_EN
    // Saturating event counters; an out-of-range access counts only as an error
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_rd  <= '0;
            perf_wr  <= '0;
            perf_err <= '0;
        end else begin
            if (arr_re && perf_rd != '1) begin
                perf_rd <= perf_rd + 1'b1;
            end
            if (arr_we && perf_wr != '1) begin
                perf_wr <= perf_wr + 1'b1;
            end
            if (accept && !in_range && perf_err != '1) begin
                perf_err <= perf_err + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl with a behavioural memory model
module tb_dmem_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1000;
    localparam int RD_LAT = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] perf_rd;
    logic [31:0] perf_wr;
    logic [31:0] perf_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [0:1023];
    int m_rd = 0;
    int m_wr = 0;
    int m_err = 0;

    dmem_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
`ifdef DMEM_PERF_CNT_EN
        ,
        .perf_rd   (perf_rd),
        .perf_wr   (perf_wr),
        .perf_err  (perf_err)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction; enable is dropped for st_len edges starting after edge st_after
    task automatic run(input bit we, input logic [9:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int st_after, input int st_len,
                       output logic [31:0] got);
        bit          inr;
        int          exp_n;
        logic [31:0] exp_d;
        int          n;
        bit          seen;
        inr   = (a < DEPTH);
        exp_d = 32'h0;
        exp_n = 0;
        if (!inr) begin
            m_err++;
        end else if (we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mdl[a][i*8 +: 8] = wd[i*8 +: 8];
            m_wr++;
        end else begin
            exp_d = mdl[a];
            exp_n = RD_LAT;
            if (st_after < RD_LAT) exp_n += st_len;
            m_rd++;
        end
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        chk("ready_idle", req_ready, 1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        n    = 0;
        seen = 0;
        while (!seen && n <= 40) begin
            if (rsp_valid === 1'b1) begin
                seen = 1;
            end else begin
                chk("ready_busy", req_ready, 0);
                @(negedge clock);
                enable = !(n >= st_after && n < st_after + st_len);
                @(posedge clock);
                #1;
                n++;
            end
        end
        enable = 1'b1;
        chk("rsp_seen", seen, 1);
        chk("latency", n, exp_n);
        chk("no_overlap", req_ready, 0);
        chk("rsp_rdata", rsp_rdata, exp_d);
        chk("rsp_err", rsp_err, !inr);
        got = rsp_rdata;
        @(posedge clock);
        #1;
        chk("rsp_drop", rsp_valid, 0);
        chk("ready_back", req_ready, 1);
    endtask

    initial begin
        bit          we;
        logic [9:0]  a;
        logic [31:0] got;
        int          r;
        int          sl;
        int          sa;

        reset     = 1'b1;
        enable    = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;

        // Reset state
        @(posedge clock);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_rdata", rsp_rdata, 0);
`ifdef DMEM_PERF_CNT_EN
        chk("rst_perf_rd", perf_rd, 0);
        chk("rst_perf_wr", perf_wr, 0);
        chk("rst_perf_err", perf_err, 0);
`endif

        // Preload the region used by the random phase
        for (int i = 0; i < 64; i++) run(1'b1, 10'(i), $urandom, 4'hF, 0, 0, got);
        run(1'b1, 10'd999, 32'h0BAD_F00D, 4'hF, 0, 0, got);

        // Full word write then read with latency RD_LAT
        run(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 0, 0, got);
        run(1'b0, 10'd5, 32'h0, 4'h0, 99, 0, got);
        chk("deadbeef", got, 32'hDEADBEEF);

        // Byte lane merge
        run(1'b1, 10'd7, 32'h11223344, 4'hF, 0, 0, got);
        run(1'b1, 10'd7, 32'hAABBCCDD, 4'b0101, 0, 0, got);
        run(1'b0, 10'd7, 32'h0, 4'h0, 99, 0, got);
        chk("byte_lanes", got, 32'h11BB33DD);

        // Zero byte-enable write is acknowledged and changes nothing
        run(1'b1, 10'd7, 32'hFFFFFFFF, 4'h0, 0, 0, got);
        run(1'b0, 10'd7, 32'h0, 4'h0, 99, 0, got);
        chk("be_zero", got, 32'h11BB33DD);

        // Out of range read and write; neighbouring in-range word unaffected
        run(1'b0, 10'd1000, 32'h0, 4'h0, 99, 0, got);
        run(1'b1, 10'd1023, 32'h12345678, 4'hF, 0, 0, got);
        run(1'b0, 10'd999, 32'h0, 4'h0, 99, 0, got);
        chk("addr999", got, 32'h0BAD_F00D);

        // Four-cycle stall in the middle of a read
        run(1'b0, 10'd5, 32'h0, 4'h0, 1, 4, got);
        chk("stall_data", got, 32'hDEADBEEF);

        // Pending response held through a stall, dropped one cycle after enable returns
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 10'd30;
        req_wdata = 32'hCAFE0030;
        req_be    = 4'hF;
        mdl[30]   = 32'hCAFE0030;
        m_wr++;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        chk("hold_rsp_first", rsp_valid, 1);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            chk("hold_rsp", rsp_valid, 1);
            chk("hold_ready", req_ready, 0);
        end
        enable = 1'b1;
        @(posedge clock);
        #1;
        chk("hold_drop", rsp_valid, 0);
        chk("hold_ready_back", req_ready, 1);
        run(1'b0, 10'd30, 32'h0, 4'h0, 99, 0, got);

        // Randomized traffic against the model
        for (int k = 0; k < 60; k++) begin
            we = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 7);
            a  = (r == 0) ? 10'(1000 + $urandom_range(0, 23)) : 10'($urandom_range(0, 63));
            sl = (!we && $urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
            sa = $urandom_range(0, 2);
            run(we, a, $urandom, 4'($urandom_range(0, 15)), sa, sl, got);
        end

        // Write accepted then reset during its response: data retained
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 10'd40;
        req_wdata = 32'h40404040;
        req_be    = 4'hF;
        mdl[40]   = 32'h40404040;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        // Reset during RD_WAIT abandons the read
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 10'd40;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < RD_LAT + 2; i++) begin
            @(posedge clock);
            #1;
            chk("abandoned_no_rsp", rsp_valid, 0);
        end
        m_rd  = 0;
        m_wr  = 0;
        m_err = 0;

        // Two reads, one write, one error after reset
        run(1'b0, 10'd40, 32'h0, 4'h0, 99, 0, got);
        chk("write_retained", got, 32'h40404040);
        run(1'b1, 10'd41, 32'h41414141, 4'hF, 0, 0, got);
        run(1'b0, 10'd41, 32'h0, 4'h0, 99, 0, got);
        run(1'b0, 10'd1010, 32'h0, 4'h0, 99, 0, got);
`ifdef DMEM_PERF_CNT_EN
        chk("perf_rd", perf_rd, 32'(m_rd));
        chk("perf_wr", perf_wr, 32'(m_wr));
        chk("perf_err", perf_err, 32'(m_err));
        chk("perf_rd_const", perf_rd, 2);
        chk("perf_wr_const", perf_wr, 1);
        chk("perf_err_const", perf_err, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
